// File: rtl/text_console.sv
// Text-mode console writer: owns the character VRAM write port, clears the screen,
// and prints a byte stream (raw or hex) at a hardware cursor with wrap and row clearing.
module text_console #(
    parameter int         COLS       = 80,
    parameter int         ROWS       = 25,
    parameter int         ADDR_W     = 12,
    parameter logic [7:0] BLANK_ATTR = 8'h07
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [7:0]               in_data,
    input  logic                     in_hex,
    input  logic [7:0]               in_attr,
    input  logic                     clear_req,
    output logic [ADDR_W-1:0]        vram_addr,
    output logic [15:0]              vram_data,
    output logic                     vram_we,
    output logic [$clog2(COLS)-1:0]  cursor_col,
    output logic [$clog2(ROWS)-1:0]  cursor_row,
    output logic                     busy
);

    localparam int CW    = $clog2(COLS);
    localparam int RW    = $clog2(ROWS);
    localparam int CELLS = COLS * ROWS;
    localparam logic [15:0] BLANK = {BLANK_ATTR, 8'h00};

    typedef enum logic [1:0] {
        CLEAR_ALL,
        IDLE,
        HEX_LO,
        CLEAR_ROW
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                pend_q, pend_d;
    logic [3:0]          lo_q, lo_d;
    logic [7:0]          attr_q, attr_d;
    logic [CW-1:0]       col_d;
    logic [RW-1:0]       row_d;
    logic                we_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [15:0]         data_d;

    logic                accept, is_nl, is_cr, is_bs;
    logic                col_last, row_done, all_done;
    logic [RW-1:0]       row_next;
    logic [ADDR_W-1:0]   row_base, cur_addr;

    function automatic logic [7:0] hex_digit(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
    endfunction

    assign in_ready = (state_q == IDLE) && !clear_req;
    assign busy     = (state_q != IDLE);
    assign accept   = in_ready && in_valid;
    assign is_nl    = !in_hex && (in_data == 8'h0A);
    assign is_cr    = !in_hex && (in_data == 8'h0D);
    assign is_bs    = !in_hex && (in_data == 8'h08);

    assign col_last = (cursor_col == CW'(COLS - 1));
    assign row_next = (cursor_row == RW'(ROWS - 1)) ? '0 : cursor_row + RW'(1);
    assign row_base = ADDR_W'(cursor_row) * ADDR_W'(COLS);
    assign cur_addr = row_base + ADDR_W'(cursor_col);
    assign row_done = (cnt_q == ADDR_W'(COLS - 1));
    assign all_done = (cnt_q == ADDR_W'(CELLS - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= CLEAR_ALL;
        else      state_q <= state_d;
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            CLEAR_ALL: if (all_done) state_d = IDLE;
            IDLE: begin
                if (clear_req)              state_d = CLEAR_ALL;
                else if (in_valid) begin
                    if (is_nl)              state_d = CLEAR_ROW;
                    else if (is_cr || is_bs) state_d = IDLE;
                    else if (col_last)      state_d = CLEAR_ROW;
                    else if (in_hex)        state_d = HEX_LO;
                end
            end
            HEX_LO:    state_d = col_last ? CLEAR_ROW : IDLE;
            CLEAR_ROW: if (row_done) state_d = pend_q ? HEX_LO : IDLE;
            default:   state_d = CLEAR_ALL;
        endcase
    end

    always_comb begin
        we_d   = 1'b0;
        addr_d = vram_addr;
        data_d = vram_data;
        col_d  = cursor_col;
        row_d  = cursor_row;
        cnt_d  = cnt_q;
        pend_d = pend_q;
        lo_d   = lo_q;
        attr_d = attr_q;
        case (state_q)
            CLEAR_ALL: begin
                we_d   = 1'b1;
                addr_d = cnt_q;
                data_d = BLANK;
                cnt_d  = cnt_q + ADDR_W'(1);
                if (all_done) begin
                    cnt_d  = '0;
                    col_d  = '0;
                    row_d  = '0;
                    pend_d = 1'b0;
                end
            end
            IDLE: begin
                if (clear_req) begin
                    cnt_d = '0;
                end else if (accept) begin
                    if (is_nl) begin
                        col_d  = '0;
                        row_d  = row_next;
                        cnt_d  = '0;
                        pend_d = 1'b0;
                    end else if (is_cr) begin
                        col_d = '0;
                    end else if (is_bs) begin
                        if (cursor_col != '0) begin
                            col_d  = cursor_col - CW'(1);
                            we_d   = 1'b1;
                            addr_d = cur_addr - ADDR_W'(1);
                            data_d = {in_attr, 8'h00};
                        end
                    end else begin
                        we_d   = 1'b1;
                        addr_d = cur_addr;
                        data_d = {in_attr, in_hex ? hex_digit(in_data[7:4]) : in_data};
                        lo_d   = in_data[3:0];
                        attr_d = in_attr;
                        if (col_last) begin
                            // The low digit waits in lo_q until the new row is cleared.
                            col_d  = '0;
                            row_d  = row_next;
                            cnt_d  = '0;
                            pend_d = in_hex;
                        end else begin
                            col_d = cursor_col + CW'(1);
                        end
                    end
                end
            end
            HEX_LO: begin
                we_d   = 1'b1;
                addr_d = cur_addr;
                data_d = {attr_q, hex_digit(lo_q)};
                pend_d = 1'b0;
                if (col_last) begin
                    col_d = '0;
                    row_d = row_next;
                    cnt_d = '0;
                end else begin
                    col_d = cursor_col + CW'(1);
                end
            end
            CLEAR_ROW: begin
                we_d   = 1'b1;
                addr_d = row_base + cnt_q;
                data_d = BLANK;
                cnt_d  = row_done ? '0 : cnt_q + ADDR_W'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vram_we    <= 1'b0;
            vram_addr  <= '0;
            vram_data  <= '0;
            cursor_col <= '0;
            cursor_row <= '0;
            cnt_q      <= '0;
            pend_q     <= 1'b0;
            lo_q       <= '0;
            attr_q     <= '0;
        end else begin
            vram_we    <= we_d;
            vram_addr  <= addr_d;
            vram_data  <= data_d;
            cursor_col <= col_d;
            cursor_row <= row_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            lo_q       <= lo_d;
            attr_q     <= attr_d;
        end
    end

endmodule

// File: tb/tb_text_console.sv
// Directed self-checking bench for text_console at the default 80x25 geometry.
module tb_text_console;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = 8'h00;
    logic        in_hex = 1'b0;
    logic [7:0]  in_attr = 8'h07;
    logic        clear_req = 1'b0;
    logic [11:0] vram_addr;
    logic [15:0] vram_data;
    logic        vram_we;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        logic [11:0] addr;
        logic [15:0] data;
        int          cyc;
    } wr_t;
    wr_t wq[$];

    text_console dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_hex     (in_hex),
        .in_attr    (in_attr),
        .clear_req  (clear_req),
        .vram_addr  (vram_addr),
        .vram_data  (vram_data),
        .vram_we    (vram_we),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        wr_t w;
        if (vram_we === 1'b1) begin
            w.addr = vram_addr;
            w.data = vram_data;
            w.cyc  = cyc;
            wq.push_back(w);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_we"},    32'(vram_we),    32'd0);
        check({tag, "_addr"},  32'(vram_addr),  32'd0);
        check({tag, "_data"},  32'(vram_data),  32'd0);
        check({tag, "_ready"}, 32'(in_ready),   32'd0);
        check({tag, "_busy"},  32'(busy),       32'd1);
        check({tag, "_col"},   32'(cursor_col), 32'd0);
        check({tag, "_row"},   32'(cursor_row), 32'd0);
    endtask

    // One comparison per write: {addr,data} of queue entry idx, or all-ones if missing.
    task automatic check_wr(input string tag, input int idx, input logic [11:0] a, input logic [15:0] d);
        logic [31:0] got;
        got = (idx < wq.size()) ? {4'h0, wq[idx].addr, wq[idx].data} : 32'hFFFF_FFFF;
        check(tag, got, {4'h0, a, d});
    endtask

    // Run of n writes with ascending addresses on consecutive cycles; counts bad entries.
    task automatic check_run(input string tag, input int first, input int base, input int n, input logic [15:0] d);
        int bad = 0;
        for (int i = 0; i < n; i++) begin
            int idx = first + i;
            if (idx >= wq.size()) bad++;
            else if (wq[idx].addr != 12'(base + i) || wq[idx].data != d) bad++;
            else if (i > 0 && wq[idx].cyc != wq[idx-1].cyc + 1) bad++;
        end
        check(tag, 32'(bad), 32'd0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", 32'd1, 32'd0);
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic h, input logic [7:0] a);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_hex   = h;
        in_attr  = a;
        while (!in_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("send_timeout", 32'd1, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_n(input int n, input logic [7:0] d);
        for (int i = 0; i < n; i++) send(d, 1'b0, 8'h07);
    endtask

    initial begin
        logic [7:0] hello [5];
        hello = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};

        // Reset and power-up clear
        #2 rst = 1'b0;
        #1 check_reset_vals("rst");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        wait_idle();
        check("clr_count", 32'(wq.size()), 32'd2000);
        check_run("clr_run", 0, 0, 2000, 16'h0700);
        check("clr_ready", 32'(in_ready), 32'd1);
        check("clr_cursor", {cursor_row, cursor_col}, 32'd0);

        // "Hello" back to back
        wq.delete();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = hello[i];
            in_hex   = 1'b0;
            in_attr  = 8'h07;
            check("hello_ready", 32'(in_ready), 32'd1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        wait_idle();
        check("hello_count", 32'(wq.size()), 32'd5);
        for (int i = 0; i < 5; i++) check_wr("hello_wr", i, 12'(i), {8'h07, hello[i]});
        if (wq.size() == 5) check("hello_timing", 32'(wq[4].cyc - wq[0].cyc), 32'd4);
        check("hello_col", 32'(cursor_col), 32'd5);

        // Hex 1C at (0,8)
        send_n(3, 8'h20);
        wait_idle();
        wq.delete();
        send(8'h1C, 1'b1, 8'h07);
        check("hex_ready_lo", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("hex_ready_back", 32'(in_ready), 32'd1);
        wait_idle();
        check("hex_count", 32'(wq.size()), 32'd2);
        check_wr("hex_hi", 0, 12'd8, 16'h0731);
        check_wr("hex_lo", 1, 12'd9, 16'h0743);
        check("hex_col", 32'(cursor_col), 32'd10);

        // CR, backspace at col 3, backspace at col 0
        wq.delete();
        send(8'h0D, 1'b0, 8'h07);
        wait_idle();
        check("cr_nowrite", 32'(wq.size()), 32'd0);
        check("cr_col", 32'(cursor_col), 32'd0);
        send_n(3, 8'h78);
        wait_idle();
        wq.delete();
        send(8'h08, 1'b0, 8'h1E);
        wait_idle();
        check("bs_count", 32'(wq.size()), 32'd1);
        check_wr("bs_wr", 0, 12'd2, 16'h1E00);
        check("bs_col", 32'(cursor_col), 32'd2);
        send(8'h0D, 1'b0, 8'h07);
        wq.delete();
        send(8'h08, 1'b0, 8'h07);
        wait_idle();
        check("bs0_nowrite", 32'(wq.size()), 32'd0);
        check("bs0_col", 32'(cursor_col), 32'd0);

        // Newline at row 2 col 5
        send(8'h0A, 1'b0, 8'h07);
        send(8'h0A, 1'b0, 8'h07);
        wait_idle();
        send_n(5, 8'h2A);
        wait_idle();
        wq.delete();
        send(8'h0A, 1'b0, 8'h07);
        wait_idle();
        check("nl_count", 32'(wq.size()), 32'd80);
        check_run("nl_clear", 0, 240, 80, 16'h0700);
        check("nl_cursor", {cursor_row, cursor_col}, {25'd3, 7'd0});

        // Line wrap from (79,24) to top
        for (int i = 0; i < 21; i++) send(8'h0A, 1'b0, 8'h07);
        wait_idle();
        send_n(79, 8'h2E);
        wait_idle();
        check("pre_wrap_cursor", {cursor_row, cursor_col}, {25'd24, 7'd79});
        wq.delete();
        send(8'h41, 1'b0, 8'h07);
        wait_idle();
        check("wrap_count", 32'(wq.size()), 32'd81);
        check_wr("wrap_char", 0, 12'd1999, 16'h0741);
        check_run("wrap_clear", 1, 0, 80, 16'h0700);
        if (wq.size() > 1) check("wrap_gap", 32'(wq[1].cyc - wq[0].cyc), 32'd1);
        check("wrap_cursor", {cursor_row, cursor_col}, 32'd0);

        // Hex straddling the line end
        send_n(79, 8'h2D);
        wait_idle();
        wq.delete();
        send(8'hFF, 1'b1, 8'h07);
        wait_idle();
        check("strad_count", 32'(wq.size()), 32'd82);
        check_wr("strad_hi", 0, 12'd79, 16'h0746);
        check_run("strad_clear", 1, 80, 80, 16'h0700);
        check_wr("strad_lo", 81, 12'd80, 16'h0746);
        check("strad_cursor", {cursor_row, cursor_col}, {25'd1, 7'd1});

        // clear_req beats a pending byte
        wq.delete();
        in_valid  = 1'b1;
        in_data   = 8'h5A;
        in_hex    = 1'b0;
        clear_req = 1'b1;
        #1 check("creq_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        clear_req = 1'b0;
        in_valid  = 1'b0;
        check("creq_busy", 32'(busy), 32'd1);
        wait_idle();
        check("creq_count", 32'(wq.size()), 32'd2000);
        check_run("creq_run", 0, 0, 2000, 16'h0700);
        check("creq_cursor", {cursor_row, cursor_col}, 32'd0);

        // Reset in the middle of a row clear
        send(8'h0A, 1'b0, 8'h07);
        repeat (10) @(negedge clk);
        check("mid_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        #1 check_reset_vals("mid_rst");
        wq.delete();
        @(negedge clk);
        rst = 1'b1;
        wait_idle();
        check("rerst_count", 32'(wq.size()), 32'd2000);
        check_run("rerst_run", 0, 0, 2000, 16'h0700);

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
